// File: rtl/mips_memory_access_unit.sv
// ---------------------------------------------------------------------------
// mips_memory_access_unit
//
// Purpose:
//   Memory-stage access engine for a MIPS-style pipeline. It accepts one
//   load/store request from the pipeline and checks its alignment. Aligned
//   requests become one word-wide request on a simple req/ack memory port.
//   Loads return aligned, sign- or zero-extended data. The pipeline is
//   stalled (busy) while a request is outstanding.
//
// Handshake (memory side):
//   mem_req is raised the cycle after a request is accepted. mem_req,
//   mem_we, mem_addr, mem_mask and mem_wdata stay stable until mem_ack is
//   sampled high on a rising clock edge. mem_req drops in the following
//   cycle. mem_ack is ignored whenever no request is outstanding. If
//   mem_ack has not arrived after TIMEOUT request cycles, the request is
//   abandoned and a timeout fault is reported.
//
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   start                   : pipeline presents an access this cycle
//   write_enable            : 1 = store, 0 = load
//   byte_enable [1:0]       : 0 none, 1 byte, 2 half, 3 word
//   byte_extend             : 0 sign-extend, 1 zero-extend (loads)
//   address [31:0]          : byte address
//   store_data [31:0]       : right-justified store data
//   busy                    : stall request to the pipeline
//   done                    : one-cycle completion pulse
//   load_data [31:0]        : result of the most recent successful load
//   fault [1:0]             : with done: 0 none, 1 misaligned, 2 timeout
//   mem_req/mem_we          : memory request / write strobe
//   mem_addr [29:0]         : word address
//   mem_mask [3:0]          : little-endian byte-lane mask
//   mem_wdata [31:0]        : lane-replicated store data
//   mem_ack, mem_rdata      : memory acknowledge and read data
// ---------------------------------------------------------------------------
module mips_memory_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        write_enable,
    input  logic [1:0]  byte_enable,
    input  logic        byte_extend,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] BE_NONE = 2'd0;
    localparam logic [1:0] BE_BYTE = 2'd1;
    localparam logic [1:0] BE_HALF = 2'd2;
    localparam logic [1:0] BE_WORD = 2'd3;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN  = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic            ext_q, ext_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      mask_q, mask_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      fault_q, fault_d;
    logic [31:0]     load_data_q, load_data_d;

    logic            accept;
    logic            misaligned;
    logic [3:0]      lane_mask;
    logic [31:0]     lane_wdata;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_extended;

    // Request decode from the live pipeline inputs (used only at accept).
    always_comb begin
        accept     = (state_q == IDLE) && start && (byte_enable != BE_NONE);
        misaligned = ((byte_enable == BE_HALF) && address[0]) ||
                     ((byte_enable == BE_WORD) && (address[1:0] != 2'b00));

        lane_mask  = 4'b0000;
        lane_wdata = store_data;
        case (byte_enable)
            BE_BYTE: begin
                lane_mask  = 4'b0001 << address[1:0];
                lane_wdata = {4{store_data[7:0]}};
            end
            BE_HALF: begin
                lane_mask  = address[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
            end
            BE_WORD: begin
                lane_mask  = 4'b1111;
                lane_wdata = store_data;
            end
            default: begin
                lane_mask  = 4'b0000;
                lane_wdata = store_data;
            end
        endcase
    end

    // Load extraction from the returned word using the latched request.
    always_comb begin
        rd_byte = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        // byte_extend = 1 selects zero extension, so the sign bit is masked.
        case (be_q)
            BE_BYTE: rd_extended = {{24{rd_byte[7] & ~ext_q}}, rd_byte};
            BE_HALF: rd_extended = {{16{rd_half[15] & ~ext_q}}, rd_half};
            default: rd_extended = mem_rdata;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        be_d        = be_q;
        ext_d       = ext_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        fault_d     = fault_q;
        load_data_d = load_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = write_enable;
                    be_d    = byte_enable;
                    ext_d   = byte_extend;
                    addr_d  = address;
                    mask_d  = lane_mask;
                    wdata_d = lane_wdata;
                    cnt_d   = '0;
                    if (misaligned) begin
                        // Reported without ever touching the memory port.
                        fault_d = FAULT_MISALIGN;
                        state_d = RESPOND;
                    end else begin
                        fault_d = FAULT_NONE;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final allowed cycle still wins over timeout.
                if (mem_ack) begin
                    fault_d = FAULT_NONE;
                    if (!we_q) begin
                        load_data_d = rd_extended;
                    end
                    state_d = RESPOND;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fault_d = FAULT_TIMEOUT;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= BE_NONE;
            ext_q       <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            fault_q     <= FAULT_NONE;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            be_q        <= be_d;
            ext_q       <= ext_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            fault_q     <= fault_d;
            load_data_q <= load_data_d;
        end
    end

    // Outputs. busy covers the accept cycle combinationally so the
    // pipeline holds the instruction in the same cycle it is presented.
    always_comb begin
        busy      = accept || (state_q == ACCESS);
        done      = (state_q == RESPOND);
        fault     = (state_q == RESPOND) ? fault_q : FAULT_NONE;
        load_data = load_data_q;
        mem_req   = (state_q == ACCESS);
        mem_we    = we_q;
        mem_addr  = addr_q[31:2];
        mem_mask  = mask_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mips_memory_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_memory_access_unit
//
// Directed scenarios followed by randomized accesses. Expected values come
// from a behavioural model of the load/store rules (shifts and arithmetic on
// whole words), tracked alongside the stimulus.
// ---------------------------------------------------------------------------
module tb_mips_memory_access_unit;

    localparam int TIMEOUT = 255;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        write_enable;
    logic [1:0]  byte_enable;
    logic        byte_extend;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_load   = 32'h0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    mips_memory_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .write_enable (write_enable),
        .byte_enable  (byte_enable),
        .byte_extend  (byte_extend),
        .address      (address),
        .store_data   (store_data),
        .busy         (busy),
        .done         (done),
        .load_data    (load_data),
        .fault        (fault),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_mask     (mem_mask),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic [3:0] model_mask(input logic [1:0] be, input logic [31:0] a);
        int lane;
        lane = int'(a[1:0]);
        if (be == 2'd1) return 4'(1 << lane);
        if (be == 2'd2) return 4'(3 << (lane & 2));
        if (be == 2'd3) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] be, input logic [31:0] d);
        if (be == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (be == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] be, input logic ext,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (be == 2'd1) begin
            v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
            if (!ext && v >= 32'd128) v = v - 32'd256;
        end else if (be == 2'd2) begin
            v = (rd >> (8 * (int'(a[1:0]) & 2))) & 32'hFFFF;
            if (!ext && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [1:0] be, input logic [31:0] a);
        return (be == 2'd2 && (a % 2) != 0) || (be == 2'd3 && (a % 4) != 0);
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start        = 1'b0;
        write_enable = 1'b0;
        byte_enable  = 2'd0;
        byte_extend  = 1'b0;
        address      = 32'h0;
        store_data   = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
    endtask

    // Presents one access at cycle N and follows it to completion.
    // ack_delay = number of request cycles before mem_ack; >= TIMEOUT never acks.
    task automatic run_access(input logic we, input logic [1:0] be, input logic ext,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int ack_delay);
        logic [3:0]  emask;
        logic [31:0] ewdata;
        bit          timed_out;
        start        = 1'b1;
        write_enable = we;
        byte_enable  = be;
        byte_extend  = ext;
        address      = a;
        store_data   = sd;
        @(negedge clock);
        chk("busy_at_accept", 32'(busy), 32'(be != 2'd0));
        chk("done_at_accept", 32'(done), 32'd0);
        next_cycle();
        start = 1'b0;

        if (be == 2'd0) begin
            @(negedge clock);
            chk("noop_done", 32'(done), 32'd0);
            chk("noop_busy", 32'(busy), 32'd0);
            chk("noop_req", 32'(mem_req), 32'd0);
            next_cycle();
            return;
        end

        if (model_misaligned(be, a)) begin
            @(negedge clock);
            chk("misal_done", 32'(done), 32'd1);
            chk("misal_fault", 32'(fault), 32'd1);
            chk("misal_req", 32'(mem_req), 32'd0);
            chk("misal_busy", 32'(busy), 32'd0);
            chk("misal_load", load_data, exp_load);
            next_cycle();
            @(negedge clock);
            chk("misal_done_clear", 32'(done), 32'd0);
            next_cycle();
            return;
        end

        emask  = model_mask(be, a);
        ewdata = model_wdata(be, sd);
        for (int k = 0; k < TIMEOUT; k++) begin
            // Garbage on the pipeline side must be ignored while not idle.
            start        = 1'($urandom_range(0, 1));
            write_enable = 1'($urandom_range(0, 1));
            byte_enable  = 2'($urandom_range(0, 3));
            address      = $urandom;
            if (k == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            @(negedge clock);
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_we", 32'(mem_we), 32'(we));
            chk("acc_addr", 32'(mem_addr), a >> 2);
            chk("acc_mask", 32'(mem_mask), 32'(emask));
            chk("acc_wdata", mem_wdata, ewdata);
            chk("acc_busy", 32'(busy), 32'd1);
            chk("acc_done", 32'(done), 32'd0);
            next_cycle();
            mem_ack = 1'b0;
            start   = 1'b0;
            if (k == ack_delay) break;
        end

        timed_out = (ack_delay >= TIMEOUT);
        if (!timed_out && !we) exp_load = model_load(be, ext, a, rd);
        // A stray ack while responding must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
        @(negedge clock);
        chk("resp_done", 32'(done), 32'd1);
        chk("resp_fault", 32'(fault), timed_out ? 32'd2 : 32'd0);
        chk("resp_load", load_data, exp_load);
        chk("resp_req", 32'(mem_req), 32'd0);
        chk("resp_busy", 32'(busy), 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("post_done", 32'(done), 32'd0);
        chk("post_fault", 32'(fault), 32'd0);
        chk("post_load", load_data, exp_load);
        next_cycle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        idle_inputs();
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_mask", 32'(mem_mask), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_load", load_data, 32'd0);
        next_cycle();

        // lb 0x1003, ack after two waits
        run_access(1'b0, 2'd1, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 2);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        // lhu 0x2002, immediate ack
        run_access(1'b0, 2'd2, 1'b1, 32'h0000_2002, 32'h0, 32'h9ABC_1234, 0);
        chk("lhu_value", load_data, 32'h0000_9ABC);
        // sb 0x3001
        run_access(1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_00A5, 32'h0, 1);
        chk("sb_keeps_load", load_data, 32'h0000_9ABC);
        // lw 0x4002 misaligned
        run_access(1'b0, 2'd3, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 0);
        // byte_enable none is a no-op
        run_access(1'b0, 2'd0, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 0);
        // lw never acknowledged
        run_access(1'b0, 2'd3, 1'b0, 32'h0000_4400, 32'h0, 32'h0, TIMEOUT);

        // mem_ack while idle is ignored
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("idle_ack_done", 32'(done), 32'd0);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clock);
        chk("idle_ack_load", load_data, exp_load);
        next_cycle();

        // reset during ACCESS
        start        = 1'b1;
        write_enable = 1'b0;
        byte_enable  = 2'd3;
        address      = 32'h0000_6000;
        next_cycle();
        start = 1'b0;
        @(negedge clock);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n  = 1'b1;
        exp_load = 32'h0;
        @(negedge clock);
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_fault", 32'(fault), 32'd0);
        chk("midrst_mask", 32'(mem_mask), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_load", load_data, 32'd0);
        next_cycle();
        @(negedge clock);
        chk("midrst_no_done", 32'(done), 32'd0);
        next_cycle();
        run_access(1'b0, 2'd3, 1'b0, 32'h0000_5000, 32'h0, 32'h1357_9BDF, 0);
        chk("lw_after_rst", load_data, 32'h1357_9BDF);

        // randomized accesses
        for (int i = 0; i < 60; i++) begin
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 4)));
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
